// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick/square-wave timebase with one-shot mode and global freeze.
// Outputs are registered (first tick N active cycles after restart); no backpressure, freeze/en simply hold state.
module tick_gen_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              freeze,
  input  logic [NUM_CH-1:0] clr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] done
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Divisors below 2 cannot produce a separate low and high phase.
  logic [CNT_W-1:0] div_in;
  assign div_in = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;
    logic             os_q;
    logic             tick_q;
    logic             sq_q;
    logic             done_q;
    logic             cfg_hit;
    logic             active;
    logic             wrap;

    assign cfg_hit = cfg_we && (cfg_ch == 4'(i));
    assign active  = en[i] && !freeze && !done_q;
    assign cnt_inc = cnt_q + ONE;
    assign half    = div_q >> 1;
    assign wrap    = (cnt_inc == div_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        os_q   <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (cfg_hit) begin
        div_q  <= div_in;
        os_q   <= cfg_oneshot;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (clr[i]) begin
        // Clear beats a coincident wrap, so no tick escapes.
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (active) begin
        if (wrap) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
          sq_q   <= 1'b0;
          done_q <= os_q;
        end else begin
          cnt_q  <= cnt_inc;
          tick_q <= 1'b0;
          sq_q   <= (cnt_inc >= half);
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: driver pushes model predictions, monitor pops and compares.
module tb_tick_gen_multi;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int DEF_DIV = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              freeze = 1'b0;
  logic [NUM_CH-1:0] clr = '0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] done;

  tick_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freeze(freeze), .clr(clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
    .tick(tick), .sq(sq), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] done;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: active cycles elapsed since the last restart, plus period and mode.
  int unsigned m_e [NUM_CH];
  int unsigned m_n [NUM_CH];
  bit          m_os[NUM_CH];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_e[i]  = 0;
      m_n[i]  = DEF_DIV;
      m_os[i] = 1'b0;
    end
  endfunction

  task automatic step(input logic [3:0] i_en, input logic i_frz, input logic [3:0] i_clr,
                      input logic i_we, input logic [3:0] i_ch, input logic [31:0] i_div,
                      input logic i_os);
    exp_t x;
    bit   dn;
    x = '0;
    @(negedge clk);
    en = i_en; freeze = i_frz; clr = i_clr;
    cfg_we = i_we; cfg_ch = i_ch; cfg_div = i_div; cfg_oneshot = i_os;
    for (int i = 0; i < NUM_CH; i++) begin
      dn = m_os[i] && (m_e[i] >= m_n[i]);
      if (i_we && (int'(i_ch) == i)) begin
        m_n[i]  = (i_div < 2) ? 2 : i_div;
        m_os[i] = i_os;
        m_e[i]  = 0;
      end else if (i_clr[i]) begin
        m_e[i] = 0;
      end else if (i_en[i] && !i_frz && !dn) begin
        m_e[i]++;
        x.tick[i] = ((m_e[i] % m_n[i]) == 0);
      end
      x.sq[i]   = ((m_e[i] % m_n[i]) >= (m_n[i] / 2));
      x.done[i] = m_os[i] && (m_e[i] >= m_n[i]);
    end
    sb_q.push_back(x);
  endtask

  task automatic idle_inputs();
    en = '0; freeze = 1'b0; clr = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("tick", 32'(tick), 32'(x.tick));
        check("sq",   32'(sq),   32'(x.sq));
        check("done", 32'(done), 32'(x.done));
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq",   32'(sq),   32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Channel 0 free-running at the reset period.
    repeat (25) step(4'b0001, 0, 4'b0000, 0, 0, 0, 0);

    // One-shot on ch2, then re-arm with clear.
    step(4'b0001, 0, 4'b0000, 1, 2, 7, 1);
    repeat (20) step(4'b0101, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0101, 0, 4'b0100, 0, 0, 0, 0);
    repeat (10) step(4'b0101, 0, 4'b0000, 0, 0, 0, 0);

    // Freeze ch0 at cnt=4 for three cycles.
    step(4'b0001, 0, 4'b0001, 0, 0, 0, 0);
    repeat (4) step(4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    repeat (3) step(4'b0001, 1, 4'b0000, 0, 0, 0, 0);
    repeat (15) step(4'b0001, 0, 4'b0000, 0, 0, 0, 0);

    // Divisor clamp on ch1: 0 and 1 both act as 2.
    step(4'b0011, 0, 4'b0000, 1, 1, 0, 0);
    repeat (6) step(4'b0011, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0011, 0, 4'b0000, 1, 1, 1, 0);
    repeat (6) step(4'b0011, 0, 4'b0000, 0, 0, 0, 0);

    // Clear on the wrap edge of ch0; config and clear together on ch3.
    step(4'b0001, 0, 4'b0001, 0, 0, 0, 0);
    repeat (9) step(4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b0001, 0, 4'b0001, 0, 0, 0, 0);
    repeat (12) step(4'b0001, 0, 4'b0000, 0, 0, 0, 0);
    step(4'b1001, 0, 4'b1000, 1, 3, 5, 0);
    repeat (12) step(4'b1001, 0, 4'b0000, 0, 0, 0, 0);

    // Asynchronous reset between edges, mid-count.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_sq",   32'(sq),   32'd0);
    check("arst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Out-of-range channel write must be ignored.
    step(4'b1111, 0, 4'b0000, 1, 5, 3, 1);
    repeat (25) step(4'b1111, 0, 4'b0000, 0, 0, 0, 0);

    // Randomized traffic.
    repeat (3000) begin
      logic [3:0]  r_en, r_clr, r_ch;
      logic        r_frz, r_we, r_os;
      logic [31:0] r_div;
      r_en  = 4'($urandom) | 4'($urandom);
      r_frz = ($urandom_range(0, 9) == 0);
      r_clr = 4'($urandom & $urandom & $urandom & $urandom);
      r_we  = ($urandom_range(0, 7) == 0);
      r_ch  = 4'($urandom_range(0, 5));
      r_div = 32'($urandom_range(0, 12));
      r_os  = 1'($urandom);
      step(r_en, r_frz, r_clr, r_we, r_ch, r_div, r_os);
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
